// File: rtl/flt_addsub_seq.sv
// flt_addsub_seq: multi-cycle float adder/subtractor, start/done handshake.
// Bit-serial align and normalise, round-to-nearest-even via G/R/S.
`timescale 1ns/1ps
module flt_addsub_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         unf
);

  localparam int CW = $clog2(MAN_W + 4);
  localparam int AW = MAN_W + 5;
  localparam logic [EXP_W:0] E_ONE = 1;
  localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [CW-1:0] C_ONE = 1;
  localparam logic [CW-1:0] C_LAST = CW'(MAN_W + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [W-1:0]   a_q, a_n;
  logic [W-1:0]   b_q, b_n;
  logic           op_q, op_n;
  logic           sub_q, sub_n;
  logic           xs, xs_n;
  logic [EXP_W:0] xe, xe_n;
  logic [EXP_W:0] d, d_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [MAN_W:0] xm, xm_n;
  logic [MAN_W:0] ym, ym_n;
  logic           g, g_n;
  logic           r, r_n;
  logic           s, s_n;
  logic [AW-1:0]  acc, acc_n;
  logic [W-1:0]   res_n;
  logic           ovf_n;
  logic           unf_n;

  logic           sbe;
  logic           za;
  logic           zb;
  logic           a_ge;
  logic [W-2:0]   big;
  logic [W-2:0]   sml;
  logic [EXP_W:0] d_init;
  logic [AW-1:0]  add_x;
  logic [AW-1:0]  add_y;
  logic [AW-1:0]  sum;
  logic           inc;
  logic [MAN_W+1:0] msum;
  logic [MAN_W-1:0] rfrac;
  logic [EXP_W:0] re;

  assign sbe    = b_q[W-1] ^ op_q;
  assign za     = (a_q[W-2:MAN_W] == '0);
  assign zb     = (b_q[W-2:MAN_W] == '0);
  assign a_ge   = (a_q[W-2:0] >= b_q[W-2:0]);
  assign big    = a_ge ? a_q[W-2:0] : b_q[W-2:0];
  assign sml    = a_ge ? b_q[W-2:0] : a_q[W-2:0];
  assign d_init = {1'b0, big[W-2:MAN_W]}
                - {1'b0, sml[W-2:MAN_W]};

  assign add_x = {1'b0, xm, 3'b000};
  assign add_y = {1'b0, ym, g, r, s};
  assign sum   = sub_q ? (add_x - add_y)
                       : (add_x + add_y);

  assign inc   = acc[2] & (acc[1] | acc[0] | acc[3]);
  assign msum  = {1'b0, acc[MAN_W+3:3]}
               + {{(MAN_W+1){1'b0}}, inc};
  assign rfrac = msum[MAN_W+1] ? msum[MAN_W:1]
                               : msum[MAN_W-1:0];
  assign re    = msum[MAN_W+1] ? (xe + E_ONE) : xe;

  assign ready = (state == S_IDLE);
  assign done  = (state == S_DONE);

  // Next-state and datapath update for every FSM phase.
  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    sub_n   = sub_q;
    xs_n    = xs;
    xe_n    = xe;
    d_n     = d;
    cnt_n   = cnt;
    xm_n    = xm;
    ym_n    = ym;
    g_n     = g;
    r_n     = r;
    s_n     = s;
    acc_n   = acc;
    res_n   = result;
    ovf_n   = ovf;
    unf_n   = unf;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          a_n     = a;
          b_n     = b;
          op_n    = op;
          ovf_n   = 1'b0;
          unf_n   = 1'b0;
          state_n = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sub_n = a_q[W-1] ^ sbe;
        xs_n  = a_ge ? a_q[W-1] : sbe;
        xe_n  = {1'b0, big[W-2:MAN_W]};
        xm_n  = {1'b1, big[MAN_W-1:0]};
        ym_n  = {1'b1, sml[MAN_W-1:0]};
        d_n   = d_init;
        cnt_n = '0;
        g_n   = 1'b0;
        r_n   = 1'b0;
        s_n   = 1'b0;
        if (za && zb) begin
          res_n   = '0;
          state_n = S_DONE;
        end else if (za) begin
          res_n   = {sbe, b_q[W-2:0]};
          state_n = S_DONE;
        end else if (zb) begin
          res_n   = a_q;
          state_n = S_DONE;
        end else if (d_init == '0) begin
          state_n = S_ADD;
        end else begin
          state_n = S_ALIGN;
        end
      end
      S_ALIGN: begin
        ym_n  = ym >> 1;
        g_n   = ym[0];
        r_n   = g;
        s_n   = s | r;
        d_n   = d - E_ONE;
        cnt_n = cnt + C_ONE;
        if (d == E_ONE || cnt == C_LAST)
          state_n = S_ADD;
      end
      S_ADD: begin
        acc_n = sum;
        if (sum == '0) begin
          res_n   = '0;
          state_n = S_DONE;
        end else begin
          state_n = S_NORM;
        end
      end
      S_NORM: begin
        if (acc[AW-1]) begin
          acc_n   = {1'b0, acc[AW-1:2],
                     acc[1] | acc[0]};
          xe_n    = xe + E_ONE;
          state_n = S_ROUND;
        end else if (acc[AW-2]) begin
          state_n = S_ROUND;
        end else if (xe == E_ONE) begin
          res_n   = {xs, {(W-1){1'b0}}};
          unf_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          acc_n = {acc[AW-2:0], 1'b0};
          xe_n  = xe - E_ONE;
        end
      end
      S_ROUND: begin
        if (re >= E_MAX) begin
          res_n = {xs, {EXP_W{1'b1}},
                   {MAN_W{1'b0}}};
          ovf_n = 1'b1;
        end else begin
          res_n = {xs, re[EXP_W-1:0], rfrac};
        end
        state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, operand and datapath registers; reset aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 1'b0;
      sub_q  <= 1'b0;
      xs     <= 1'b0;
      xe     <= '0;
      d      <= '0;
      cnt    <= '0;
      xm     <= '0;
      ym     <= '0;
      g      <= 1'b0;
      r      <= 1'b0;
      s      <= 1'b0;
      acc    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      state  <= state_n;
      a_q    <= a_n;
      b_q    <= b_n;
      op_q   <= op_n;
      sub_q  <= sub_n;
      xs     <= xs_n;
      xe     <= xe_n;
      d      <= d_n;
      cnt    <= cnt_n;
      xm     <= xm_n;
      ym     <= ym_n;
      g      <= g_n;
      r      <= r_n;
      s      <= s_n;
      acc    <= acc_n;
      result <= res_n;
      ovf    <= ovf_n;
      unf    <= unf_n;
    end
  end

endmodule

// File: tb/tb_flt_addsub_seq.sv
// tb_flt_addsub_seq: vector table plus handshake/reset sequences.
// Expected results queued at issue, compared when done pulses.
`timescale 1ns/1ps
module tb_flt_addsub_seq;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int LIM = 2 * MAN_W + 12 + 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;
  logic         unf;

  always #5 clk = ~clk;

  flt_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .ready(ready),
    .done(done),
    .result(result),
    .ovf(ovf),
    .unf(unf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] res;
    logic         ovf;
    logic         unf;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(logic [W-1:0] va, logic [W-1:0] vb,
                              logic vo, logic [W-1:0] vr,
                              logic vv, logic vu);
    vec_t v;
    v.a = va; v.b = vb; v.op = vo;
    v.res = vr; v.ovf = vv; v.unf = vu;
    return v;
  endfunction

  task automatic chk(string nm, logic [W-1:0] act,
                     logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(vec_t v);
    @(negedge clk);
    chk("ready_idle", W'(ready), W'(1));
    a = v.a; b = v.b; op = v.op; start = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    chk("ready_busy", W'(ready), W'(0));
  endtask

  task automatic collect(string nm);
    int n = 0;
    vec_t v;
    while (!done && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) v = sb.pop_front();
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, LIM);
    end else begin
      chk({nm, "_res"}, result, v.res);
      chk({nm, "_ovf"}, W'(ovf), W'(v.ovf));
      chk({nm, "_unf"}, W'(unf), W'(v.unf));
      @(negedge clk);
      chk({nm, "_pulse"}, W'(done), W'(0));
      chk({nm, "_held"}, result, v.res);
    end
  endtask

  task automatic count_done(string nm, int cyc);
    int c = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (done) c++;
    end
    chk(nm, W'(c), W'(0));
  endtask

  initial begin
    tbl.push_back(mk(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 0, 0));
    tbl.push_back(mk(16'h4000, 16'hBE00, 1'b0, 16'h3800, 0, 0));
    tbl.push_back(mk(16'h4000, 16'h3E00, 1'b1, 16'h3800, 0, 0));
    tbl.push_back(mk(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 0, 0));
    tbl.push_back(mk(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 0, 0));
    tbl.push_back(mk(16'h3C00, 16'h1001, 1'b0, 16'h3C01, 0, 0));
    tbl.push_back(mk(16'h3E00, 16'h3E00, 1'b1, 16'h0000, 0, 0));
    tbl.push_back(mk(16'h0000, 16'h3C00, 1'b1, 16'hBC00, 0, 0));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 0, 0));
    tbl.push_back(mk(16'h0005, 16'h3C00, 1'b0, 16'h3C00, 0, 0));
    tbl.push_back(mk(16'h3C00, 16'h0000, 1'b0, 16'h3C00, 0, 0));
    tbl.push_back(mk(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1, 0));
    tbl.push_back(mk(16'h0401, 16'h0400, 1'b1, 16'h0000, 0, 1));
    tbl.push_back(mk(16'h3C01, 16'h3C00, 1'b1, 16'h1400, 0, 0));
    tbl.push_back(mk(16'h3C00, 16'h0400, 1'b0, 16'h3C00, 0, 0));
    tbl.push_back(mk(16'h4200, 16'h3C00, 1'b0, 16'h4400, 0, 0));
    tbl.push_back(mk(16'hC000, 16'h3C00, 1'b0, 16'hBC00, 0, 0));
    tbl.push_back(mk(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 0, 0));

    reset = 1'b1; start = 1'b0; op = 1'b0;
    a = '0; b = '0;
    #12;
    chk("rst_ready", W'(ready), W'(1));
    chk("rst_done", W'(done), W'(0));
    chk("rst_result", result, 16'h0000);
    chk("rst_ovf", W'(ovf), W'(0));
    chk("rst_unf", W'(unf), W'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i]);
      collect($sformatf("vec%0d", i));
    end

    // start pulsed while busy must be ignored
    issue(mk(16'h4000, 16'h3E00, 1'b1, 16'h3800, 0, 0));
    a = 16'h7BFF; b = 16'h7BFF; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect("busy_start");
    count_done("busy_no_extra", LIM);
    chk("busy_res_kept", result, 16'h3800);
    chk("busy_ovf_kept", W'(ovf), W'(0));

    // reset during normalisation aborts the operation
    @(negedge clk);
    a = 16'h3C01; b = 16'h3C00; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("norm_not_done", W'(done), W'(0));
    reset = 1'b1;
    #1;
    chk("abort_ready", W'(ready), W'(1));
    chk("abort_result", result, 16'h0000);
    chk("abort_done", W'(done), W'(0));
    @(negedge clk);
    reset = 1'b0;
    count_done("abort_no_done", LIM);

    issue(mk(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 0, 0));
    collect("after_abort");

    chk("sb_empty", W'(sb.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flt_addsub_seq.md
Name: flt_addsub_seq

Overview:
- Parametrised, multi-cycle floating-point adder/subtractor. Successor to the fixed-format behavioural float adder used by the float+float program.
- Accepts two operands in the team's sign/biased-exponent/hidden-bit format with a start/done handshake.
- Supports true net subtraction and round-to-nearest-even using G/R/S bits.
- Aligns and normalises with a one-bit-per-cycle shifter FSM. Sits beside data_mem as the arithmetic engine the controller launches and polls.

Parameters:
- EXP_W, 5: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 10: stored mantissa width; hidden bit excluded.
- W, 1+EXP_W+MAN_W (derived, localparam): operand/result width.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- start, in, 1: launch operation; sampled only when ready=1.
- op, in, 1: 0 = a+b, 1 = a-b.
- a, in, W: operand A {sign, exp, man}.
- b, in, W: operand B.
- ready, out, 1: high in IDLE only.
- done, out, 1: one-cycle pulse when result is valid.
- result, out, W: sum/difference; held until next accepted start.
- ovf, out, 1: exponent overflow on last result; held with result.
- unf, out, 1: exponent underflow (flushed to zero) on last result; held with result.

Behaviour:
- Reset (async assert) values: state=IDLE, ready=1, done=0, result=0, ovf=0, unf=0.
  - Reset mid-operation aborts immediately; no done pulse follows.
- Number format:
  - exp==0 means zero, regardless of mantissa; no denormals.
  - All other exps are normal with hidden 1.
  - exp all-ones is treated numerically on input; NaN/Inf are not recognised.
- FSM states: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- IDLE: on start&ready, register a, b, op; clear ovf/unf; ready drops next cycle. start while ready=0 is ignored.
- UNPACK (1 cycle):
  - sb_eff = b.sign ^ op; sub = a.sign ^ sb_eff.
  - Swap operands so the larger magnitude {exp,man} is X; result sign = sign of X.
  - Prepend hidden bit (!zero).
  - If either operand is zero, go straight to DONE:
    - result = the nonzero operand, with sign sb_eff if it is B.
    - Both zero -> result = +0.
- ALIGN: shift Y mantissa right 1 bit/cycle through G, R, S (S = OR of all bits shifted past R) until the exp difference is exhausted or MAN_W+3 shifts are done. Remaining shifts only OR into S.
- ADD (1 cycle): mant = X + Y (add) or X - {Y,G,R,S} (sub), at MAN_W+5 bits wide including GRS.
  - Exact zero difference -> result = +0, go to DONE.
- NORM:
  - Carry out: shift right 1, exp+1 (1 cycle).
  - Otherwise shift left 1/cycle, exp-1, until the hidden bit is set.
  - If exp would reach 0: result = +0 with sign, unf=1, go to DONE.
- ROUND (1 cycle): round to nearest even.
  - Increment if G & (R|S|lsb).
  - Round carry-out: shift right, exp+1.
  - If exp reaches all-ones: result = {sign, all-ones exp, 0}, ovf=1.
- DONE: done=1 for exactly one cycle; result/ovf/unf valid the same cycle and held afterwards; next state IDLE (ready=1).
- Latency from start accept to done:
  - Minimum 3 cycles (zero-operand path).
  - Maximum 2·MAN_W+12 cycles.
  - The bench must not depend on exact latency, only on the bound.
- All internal arithmetic is unsigned magnitude with an explicit sign; exp arithmetic carries one extra bit to detect overflow/underflow.

Test Plan:
- Add, equal exponents, carry: a=16'h3C00 (1.0), b=16'h3C00, op=0 -> result 16'h4000, ovf=0, unf=0, done single pulse.
- Net subtraction with normalise: a=16'h4000 (2.0), b=16'h3E00 (1.5), op=0 with b sign set (16'hBE00) -> result 16'h3800 (0.5). Same value via op=1, b=16'h3E00.
- Rounding ties:
  - 16'h3C00 + 16'h1000 -> 16'h3C00 (tie, even kept).
  - 16'h3C01 + 16'h1000 -> 16'h3C02 (tie, rounds up).
- Cancellation and zeros:
  - 16'h3E00 - 16'h3E00 -> 16'h0000.
  - 16'h0000 - 16'h3C00 -> 16'hBC00.
  - 16'h0000 + 16'h0000 -> 16'h0000.
- Overflow/underflow:
  - 16'h7BFF + 16'h7BFF -> 16'h7C00, ovf=1.
  - 16'h0401 - 16'h0400 -> 16'h0000, unf=1.
- Handshake/reset:
  - Pulse start while ready=0 -> ignored; result unchanged.
  - Assert reset during NORM -> ready=1 and result=0 immediately; no done pulse.
  - Next start completes normally.
